decoder_2to4_hold: RTL and testbench
====================================

// Module: decoder_2to4_hold
// PURPOSE
//  Registered 2-to-4 one-hot decoder, inverse of the 4-to-2 encoder path.
//  Accepts a 2-bit code via valid/ready, drives the matching one-hot line
//  for HOLD_CYCLES clocks, then returns to all-zero. Used to drive one-hot
//  selects or strobes such as LED, row or enable lines from encoded commands.
// PARAMETERS
//  HOLD_CYCLES  4  clocks each accepted code is held on out_onehot (>=1)
//  CNT_W        3  hold-counter width; must satisfy 2**CNT_W >= HOLD_CYCLES
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  rst_n       in   1  synchronous reset, active-low
//  in_code     in   2  encoded index 0..3
//  in_valid    in   1  in_code valid this cycle
//  in_ready    out  1  block can accept in_code this cycle
//  out_onehot  out  4  one-hot decode; 4'b0000 when idle
//  out_valid   out  1  out_onehot carries a decoded code
//  busy        out  1  code held and not in final hold cycle
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset synchronous, active-low, rst_n.
//  Reset: state=IDLE, cnt=0, out_onehot=4'b0000, out_valid=0, busy=0.
//   in_ready=1 in the first cycle after reset.
//  Accept: transfer occurs when in_valid && in_ready at posedge clk.
//  Latency: out_onehot = 4'b0001 << in_code and out_valid=1 from the cycle
//   after accept. Mapping: 0->0001, 1->0010, 2->0100, 3->1000.
//  FSM states: IDLE, HOLD.
//   IDLE: in_ready=1, outputs zero. On accept go to HOLD, cnt=HOLD_CYCLES-1.
//   HOLD: outputs stay constant; cnt decrements by 1 each cycle.
//    cnt!=0: in_ready=0, busy=1; in_valid is ignored, no stall of sender.
//    cnt==0 (final cycle): in_ready=1, busy=0.
//     Accept here: reload out_onehot and cnt; stay in HOLD; no gap cycle.
//     No accept here: go to IDLE; out_onehot=0 and out_valid=0 next cycle.
//  HOLD_CYCLES=1: cnt is always 0; behaves as a 1-cycle registered decoder
//   with full throughput, one code per clock.
//  Output rule: exactly one out_onehot bit is high iff out_valid=1; never
//   more than one bit high.
//  in_ready is combinational from state/cnt only, never from in_valid.
//  Counter: unsigned CNT_W bits, never wraps below 0.
//  Reset mid-HOLD: next edge forces reset values; held code is discarded.
//  in_valid asserted during reset is ignored; no accept while rst_n=0.
// STRUCTURE
//  Package decoder_pkg: CODE_W=2, ONEHOT_W=4, state enum {IDLE,HOLD}.
//  Sub-module hold_counter: load/decrement down-counter.
//   Ports: clk, rst_n, load, load_val, dec, cnt, zero.
//  Top holds FSM, decode register and handshake logic.
// TESTING
//  1 Reset: rst_n=0 for 2 clk -> out_onehot=0000, out_valid=0, in_ready=1.
//  2 Single code: in_code=2 accepted, HOLD_CYCLES=4 -> out_onehot=0100
//    for exactly 4 cycles starting 1 cycle after accept, then 0000.
//  3 Back-to-back: code 1 then code 3 offered in its final hold cycle ->
//    0010 x4 then 1000 x4, no zero cycle between them.
//  4 Ignored input: in_valid=1 with code 0 while cnt!=0 -> in_ready=0,
//    out_onehot unchanged until the final hold cycle.
//  5 Reset mid-HOLD: rst_n=0 on hold cycle 2 -> next cycle outputs 0000,
//    out_valid=0, state IDLE.
//  6 HOLD_CYCLES=1: codes 0,1,2,3 offered on consecutive clocks ->
//    0001,0010,0100,1000 on the following 4 clocks; checker asserts
//    $onehot0(out_onehot) every cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths, FSM state type and decode helper for the 2-to-4 hold decoder.
package decoder_pkg;

    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [ONEHOT_W-1:0] decode(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/decoder_2to4_hold_hold_counter.sv
// Load/decrement down-counter that saturates at zero; used to time the hold window.
module hold_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_2to4_hold.sv
// Registered 2-to-4 one-hot decoder: each accepted code is held on out_onehot
// for HOLD_CYCLES clocks, with a new code accepted in the final hold cycle.
module decoder_2to4_hold
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ONEHOT_W-1:0] out_onehot,
    output logic                out_valid,
    output logic                busy
);

    state_t              state;
    state_t              state_next;
    logic [ONEHOT_W-1:0] onehot_next;
    logic                accept;
    logic                cnt_load;
    logic                cnt_dec;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_zero;

    hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_W'(HOLD_CYCLES - 1)),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Ready depends only on state and counter so the sender never sees a loop.
    assign in_ready  = (state == IDLE) || cnt_zero;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state == HOLD) && (cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_onehot <= '0;
        end else begin
            state      <= state_next;
            out_onehot <= onehot_next;
        end
    end

    // The final hold cycle either reloads with a new code or drops back to idle.
    always_comb begin
        state_next  = state;
        onehot_next = out_onehot;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next  = HOLD;
                    onehot_next = decode(in_code);
                    cnt_load    = 1'b1;
                end
            end
            HOLD: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (accept) begin
                    onehot_next = decode(in_code);
                    cnt_load    = 1'b1;
                end else begin
                    state_next  = IDLE;
                    onehot_next = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                onehot_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_2to4_hold.sv
// Directed table-driven bench for decoder_2to4_hold with HOLD_CYCLES=4 and =1.
module tb_decoder_2to4_hold;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [1:0] code;
        logic [3:0] exp_onehot;
        logic       exp_valid;
        logic       exp_ready;
        logic       exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] code4;
    logic       valid4;
    logic       ready4;
    logic [3:0] onehot4;
    logic       ovalid4;
    logic       busy4;
    logic [1:0] code1;
    logic       valid1;
    logic       ready1;
    logic [3:0] onehot1;
    logic       ovalid1;
    logic       busy1;

    int   checks   = 0;
    int   failures = 0;
    logic monitor_en = 1'b0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    decoder_2to4_hold #(.HOLD_CYCLES(4), .CNT_W(3)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (code4),
        .in_valid   (valid4),
        .in_ready   (ready4),
        .out_onehot (onehot4),
        .out_valid  (ovalid4),
        .busy       (busy4)
    );

    decoder_2to4_hold #(.HOLD_CYCLES(1), .CNT_W(3)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (code1),
        .in_valid   (valid1),
        .in_ready   (ready1),
        .out_onehot (onehot1),
        .out_valid  (ovalid1),
        .busy       (busy1)
    );

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic r, input logic v, input logic [1:0] c,
                          input logic [3:0] eo, input logic ev, input logic er, input logic eb);
        vec_t t;
        t.rst_n = r; t.valid = v; t.code = c;
        t.exp_onehot = eo; t.exp_valid = ev; t.exp_ready = er; t.exp_busy = eb;
        vecs.push_back(t);
    endtask

    // Drive one vector into the HOLD_CYCLES=4 instance and check the result one edge later.
    task automatic applyStimulus(input int idx, input vec_t t);
        rst_n  = t.rst_n;
        valid4 = t.valid;
        code4  = t.code;
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_onehot", idx), onehot4, t.exp_onehot);
        checkOutput($sformatf("v%0d_valid", idx), {3'b0, ovalid4}, {3'b0, t.exp_valid});
        checkOutput($sformatf("v%0d_ready", idx), {3'b0, ready4}, {3'b0, t.exp_ready});
        checkOutput($sformatf("v%0d_busy", idx), {3'b0, busy4}, {3'b0, t.exp_busy});
    endtask

    // Both instances must never show more than one hot bit, and valid must track it.
    always @(negedge clk) begin
        if (monitor_en) begin
            checkOutput("onehot0_dut4", {3'b0, $onehot0(onehot4)}, 4'b0001);
            checkOutput("onehot0_dut1", {3'b0, $onehot0(onehot1)}, 4'b0001);
            checkOutput("valid_vs_onehot_dut4", {3'b0, ovalid4}, {3'b0, $onehot(onehot4)});
            checkOutput("valid_vs_onehot_dut1", {3'b0, ovalid1}, {3'b0, $onehot(onehot1)});
        end
    end

    initial begin
        logic [3:0] exp1 [4];
        exp1[0] = 4'b0001; exp1[1] = 4'b0010; exp1[2] = 4'b0100; exp1[3] = 4'b1000;

        rst_n = 1'b0; valid4 = 1'b0; code4 = 2'd0; valid1 = 1'b0; code1 = 2'd0;

        //     rst  v   code   onehot    ov    rdy   busy
        addVec(0, 1, 2'd3, 4'b0000, 0, 1, 0);   // valid during reset ignored
        addVec(0, 0, 2'd0, 4'b0000, 0, 1, 0);
        addVec(1, 0, 2'd0, 4'b0000, 0, 1, 0);
        addVec(1, 1, 2'd2, 4'b0100, 1, 0, 1);   // single code, 4-cycle hold
        addVec(1, 0, 2'd0, 4'b0100, 1, 0, 1);
        addVec(1, 0, 2'd0, 4'b0100, 1, 0, 1);
        addVec(1, 0, 2'd0, 4'b0100, 1, 1, 0);
        addVec(1, 0, 2'd0, 4'b0000, 0, 1, 0);
        addVec(1, 1, 2'd1, 4'b0010, 1, 0, 1);   // back-to-back start
        addVec(1, 0, 2'd0, 4'b0010, 1, 0, 1);
        addVec(1, 1, 2'd0, 4'b0010, 1, 0, 1);   // ignored while cnt!=0
        addVec(1, 1, 2'd0, 4'b0010, 1, 1, 0);
        addVec(1, 1, 2'd3, 4'b1000, 1, 0, 1);   // accepted in final cycle, no gap
        addVec(1, 0, 2'd0, 4'b1000, 1, 0, 1);
        addVec(1, 0, 2'd0, 4'b1000, 1, 0, 1);
        addVec(1, 0, 2'd0, 4'b1000, 1, 1, 0);
        addVec(1, 0, 2'd0, 4'b0000, 0, 1, 0);
        addVec(1, 1, 2'd0, 4'b0001, 1, 0, 1);   // reset mid-hold
        addVec(1, 0, 2'd0, 4'b0001, 1, 0, 1);
        addVec(0, 1, 2'd2, 4'b0000, 0, 1, 0);
        addVec(1, 0, 2'd0, 4'b0000, 0, 1, 0);
        addVec(1, 1, 2'd3, 4'b1000, 1, 0, 1);   // valid held high throughout
        addVec(1, 1, 2'd1, 4'b1000, 1, 0, 1);
        addVec(1, 1, 2'd1, 4'b1000, 1, 0, 1);
        addVec(1, 1, 2'd1, 4'b1000, 1, 1, 0);
        addVec(1, 1, 2'd1, 4'b0010, 1, 0, 1);
        addVec(0, 0, 2'd0, 4'b0000, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
            if (i == 1) monitor_en = 1'b1;
        end

        // HOLD_CYCLES=1: one code per clock with no idle gaps.
        rst_n = 1'b1; valid4 = 1'b0; valid1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("h1_ready_idle", {3'b0, ready1}, 4'b0001);
        for (int c = 0; c < 4; c++) begin
            valid1 = 1'b1;
            code1  = 2'(c);
            @(posedge clk);
            #1;
            checkOutput($sformatf("h1_onehot_c%0d", c), onehot1, exp1[c]);
            checkOutput($sformatf("h1_valid_c%0d", c), {3'b0, ovalid1}, 4'b0001);
            checkOutput($sformatf("h1_ready_c%0d", c), {3'b0, ready1}, 4'b0001);
            checkOutput($sformatf("h1_busy_c%0d", c), {3'b0, busy1}, 4'b0000);
        end
        valid1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("h1_onehot_drain", onehot1, 4'b0000);
        checkOutput("h1_valid_drain", {3'b0, ovalid1}, 4'b0000);

        @(posedge clk);
        #1;
        monitor_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
